// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command queue.
// SPI_CMD_QUEUE_INIT_EN adds the INIT state that plays INIT_TABLE after reset.
package spi_cmd_pkg;

  localparam int DEFAULT_WIDTH = 16;

`ifdef SPI_CMD_QUEUE_INIT_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_INIT
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP
  } state_t;
`endif

  // Bring-up words sent to the device before any user traffic.
  localparam int INIT_LEN = 3;
  localparam logic [DEFAULT_WIDTH-1:0] INIT_TABLE [INIT_LEN] = '{
    16'h9F00,
    16'h0601,
    16'h8042
  };

endpackage

// File: rtl/spi_cmd_queue_if.sv
// Producer write port and SPI transmitter start port of the command queue.
interface spi_cmd_queue_if
  import spi_cmd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 16
);

  logic [WIDTH-1:0]             wrData;
  logic                         wrValid;
  logic                         wrReady;
  logic [WIDTH-1:0]             spiDin;
  logic                         spiVin;
  logic                         spiBusy;
  logic [$clog2(DEPTH+1)-1:0]   level;
  logic                         idle;

  modport slave (
    input  wrData, wrValid, spiBusy,
    output wrReady, spiDin, spiVin, level, idle
  );

  modport master (
    output wrData, wrValid, spiBusy,
    input  wrReady, spiDin, spiVin, level, idle
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; head word is visible on o_data.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [LW-1:0]    r_level;
  logic             w_doPush;
  logic             w_doPop;

  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
      case ({w_doPush, w_doPop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_data;
  end

  assign o_data  = r_mem[r_rdPtr];
  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/spi_cmd_queue.sv
// Queues command words and paces them into an SPI transmitter with a GAP-cycle pause.
// Optional feature: SPI_CMD_QUEUE_INIT_EN sends INIT_TABLE once after reset.
module spi_cmd_queue
  import spi_cmd_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 16,
  parameter int GAP   = 4
) (
  input logic                clk,
  input logic                rst,
  spi_cmd_queue_if.slave     io_bus
);

  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  state_t           r_state;
  state_t           w_nextState;
  state_t           w_afterFrame;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_issue;
  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_issueData;
  logic [WIDTH-1:0] r_spiDin;
  logic             r_spiVin;
  logic [GW-1:0]    r_gapCnt;

  assign w_push = io_bus.wrValid && !w_full;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (io_bus.wrData),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (io_bus.level)
  );

`ifdef SPI_CMD_QUEUE_INIT_EN
  localparam int     IW          = $clog2(INIT_LEN + 1);
  localparam state_t RESET_STATE = ST_INIT;

  logic [IW-1:0] r_initIdx;
  logic          w_initDone;

  assign w_initDone   = (r_initIdx == IW'(INIT_LEN));
  assign w_afterFrame = w_initDone ? ST_IDLE : ST_INIT;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_initIdx <= '0;
    end else if (w_issue && r_state == ST_INIT) begin
      r_initIdx <= r_initIdx + IW'(1);
    end
  end
`else
  localparam state_t RESET_STATE = ST_IDLE;

  assign w_afterFrame = ST_IDLE;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= RESET_STATE;
    else     r_state <= w_nextState;
  end

  // The strobe is launched on the edge that enters ISSUE, so spi_vin is high during ISSUE.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_issueData = w_head;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !io_bus.spiBusy) begin
          w_nextState = ST_ISSUE;
          w_pop       = 1'b1;
          w_issue     = 1'b1;
        end
      end
      ST_ISSUE: w_nextState = ST_WAIT;
      ST_WAIT: begin
        if (!io_bus.spiBusy) w_nextState = (GAP > 0) ? ST_GAP : w_afterFrame;
      end
      ST_GAP: begin
        if (r_gapCnt <= GW'(1)) w_nextState = w_afterFrame;
      end
`ifdef SPI_CMD_QUEUE_INIT_EN
      ST_INIT: begin
        if (w_initDone) begin
          w_nextState = ST_IDLE;
        end else if (!io_bus.spiBusy) begin
          w_nextState = ST_ISSUE;
          w_issue     = 1'b1;
          w_issueData = WIDTH'(INIT_TABLE[r_initIdx]);
        end
      end
`endif
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gapCnt <= '0;
    end else if (r_state == ST_WAIT && !io_bus.spiBusy) begin
      r_gapCnt <= GW'(GAP);
    end else if (r_state == ST_GAP && r_gapCnt != '0) begin
      r_gapCnt <= r_gapCnt - GW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_spiVin <= 1'b0;
      r_spiDin <= '0;
    end else begin
      r_spiVin <= w_issue;
      if (w_issue) r_spiDin <= w_issueData;
    end
  end

  assign io_bus.wrReady = !w_full;
  assign io_bus.spiVin  = r_spiVin;
  assign io_bus.spiDin  = r_spiDin;
  assign io_bus.idle    = w_empty && (r_state == ST_IDLE) && !io_bus.spiBusy;

endmodule

// File: tb/tb_spi_cmd_queue.sv
// Directed self-checking bench for spi_cmd_queue with a simple busy-counter transmitter model.
// Define SPI_CMD_QUEUE_INIT_EN for both RTL and bench to exercise the init table.
module tb_spi_cmd_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int GAP   = 4;
  // Transmitter holds busy for FRAME cycles starting in the strobe cycle.
  localparam int FRAME = 6;
  // Strobe-to-strobe: busy span, WAIT cycle seeing busy low, GAP cycles, IDLE decision cycle.
  localparam int SPACING = FRAME + 1 + GAP + 1;

  logic clk;
  logic rst;
  logic forceBusy;
  logic [3:0] txCnt;
  int checks   = 0;
  int failures = 0;
  int cycle    = 0;
  logic [15:0] vinData [$];
  int          vinCycle[$];

  spi_cmd_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  spi_cmd_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .GAP   (GAP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk) begin
    if (rst)                txCnt <= '0;
    else if (bus.spiVin)    txCnt <= 4'(FRAME - 1);
    else if (txCnt != '0)   txCnt <= txCnt - 4'd1;
  end

  assign bus.spiBusy = bus.spiVin | (txCnt != '0) | forceBusy;

  always @(negedge clk) begin
    if (!rst && bus.spiVin) begin
      vinData.push_back(bus.spiDin);
      vinCycle.push_back(cycle);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] data);
    bus.wrValid = valid;
    bus.wrData  = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitVins(input int n, input int maxCycles);
    int k = 0;
    while (vinData.size() < n && k < maxCycles) begin
      step();
      k++;
    end
    checkOutput("strobe count", vinData.size(), n);
  endtask

  task automatic waitIdle(input int maxCycles);
    int k = 0;
    while (!bus.idle && k < maxCycles) begin
      step();
      k++;
    end
    checkOutput("return to idle", bus.idle, 1);
  endtask

  task automatic clearLog();
    vinData.delete();
    vinCycle.delete();
  endtask

  initial begin
    int n;
    logic [15:0] expWord;

    forceBusy = 1'b0;
    applyStimulus(1'b0, 16'h0000);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("reset level", bus.level, 0);
    checkOutput("reset wrReady", bus.wrReady, 1);
    checkOutput("reset spiVin", bus.spiVin, 0);
    checkOutput("reset spiDin", bus.spiDin, 0);
`ifdef SPI_CMD_QUEUE_INIT_EN
    checkOutput("reset idle during init", bus.idle, 0);

    $display("[TB] init table then user word");
    applyStimulus(1'b1, 16'h1234);
    step();
    applyStimulus(1'b0, 16'h0000);
    waitVins(4, 200);
    if (vinData.size() >= 4) begin
      checkOutput("init word 0", vinData[0], 16'h9F00);
      checkOutput("init word 1", vinData[1], 16'h0601);
      checkOutput("init word 2", vinData[2], 16'h8042);
      checkOutput("user after init", vinData[3], 16'h1234);
    end
    waitIdle(100);
    clearLog();
`else
    checkOutput("reset idle", bus.idle, 1);
`endif

    $display("[TB] single word latency");
    applyStimulus(1'b1, 16'hA5C3);
    step();
    applyStimulus(1'b0, 16'h0000);
    checkOutput("single level after accept", bus.level, 1);
    checkOutput("single no early strobe", bus.spiVin, 0);
    step();
    checkOutput("single strobe", bus.spiVin, 1);
    checkOutput("single spiDin", bus.spiDin, 16'hA5C3);
    checkOutput("single popped", bus.level, 0);
    step();
    checkOutput("single strobe width", bus.spiVin, 0);
    n = 1;
    while (!bus.idle && n < 60) begin
      step();
      n++;
    end
    checkOutput("single idle return cycles", n, FRAME + 1 + GAP);
    checkOutput("single spiDin hold", bus.spiDin, 16'hA5C3);
    clearLog();

    $display("[TB] burst of 16 with busy held");
    forceBusy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 16'h1000 + 16'(i) * 16'h0111);
      step();
    end
    applyStimulus(1'b1, 16'hDEAD);
    checkOutput("burst full level", bus.level, 16);
    checkOutput("burst wrReady low", bus.wrReady, 0);
    step();
    step();
    checkOutput("burst no overwrite", bus.level, 16);
    checkOutput("busy blocks strobe", vinData.size(), 0);
    forceBusy = 1'b0;
    step();
    checkOutput("no full bypass", bus.level, 15);
    checkOutput("burst first strobe", bus.spiVin, 1);
    applyStimulus(1'b0, 16'h0000);
    waitVins(16, 16 * SPACING + 20);
    for (int i = 0; i < 16 && i < vinData.size(); i++) begin
      expWord = 16'h1000 + 16'(i) * 16'h0111;
      checkOutput($sformatf("burst order %0d", i), vinData[i], expWord);
      if (i > 0) checkOutput($sformatf("burst spacing %0d", i), vinCycle[i] - vinCycle[i-1], SPACING);
    end
    waitIdle(60);
    clearLog();

    $display("[TB] push and pop at level 5");
    forceBusy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'h5000 + 16'(i));
      step();
    end
    applyStimulus(1'b0, 16'h0000);
    checkOutput("level five", bus.level, 5);
    forceBusy = 1'b0;
    applyStimulus(1'b1, 16'h50FF);
    step();
    applyStimulus(1'b0, 16'h0000);
    checkOutput("push pop level", bus.level, 5);
    checkOutput("push pop strobe data", bus.spiDin, 16'h5000);
    waitVins(6, 6 * SPACING + 20);
    if (vinData.size() >= 6) checkOutput("push pop last word", vinData[5], 16'h50FF);
    waitIdle(60);
    clearLog();

    $display("[TB] reset during WAIT");
    forceBusy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'h7000 + 16'(i));
      step();
    end
    applyStimulus(1'b0, 16'h0000);
    forceBusy = 1'b0;
    step();
    checkOutput("pre-reset strobe", bus.spiVin, 1);
    step();
    checkOutput("pre-reset level", bus.level, 3);
    checkOutput("pre-reset busy", bus.spiBusy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    clearLog();
    checkOutput("mid reset level", bus.level, 0);
    checkOutput("mid reset spiVin", bus.spiVin, 0);
    checkOutput("mid reset spiDin", bus.spiDin, 0);
    checkOutput("mid reset wrReady", bus.wrReady, 1);
    repeat (40) step();
`ifdef SPI_CMD_QUEUE_INIT_EN
    checkOutput("post reset only init strobes", vinData.size(), 3);
`else
    checkOutput("post reset no strobes", vinData.size(), 0);
`endif
    checkOutput("post reset level", bus.level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
